// File: rtl/fe_mul_arbiter.sv
// rtl/fe_mul_arbiter.sv - round-robin arbiter sharing one modular multiplier between requesters
module fe_mul_arbiter #(
    parameter int NUM_IN       = 4,
    parameter int DAT_BITS     = 762,
    parameter int RES_BITS     = 381,
    parameter int CTL_BITS     = 16,
    parameter int OVR_WRT_BIT  = 12,
    parameter int MAX_INFLIGHT = 16,
    localparam int IDX_BITS    = $clog2(NUM_IN),
    localparam int INF_BITS    = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    // requester streams
    input  logic [NUM_IN*DAT_BITS-1:0]   i_req_dat,
    input  logic [NUM_IN*CTL_BITS-1:0]   i_req_ctl,
    input  logic [NUM_IN-1:0]            i_req_sop,
    input  logic [NUM_IN-1:0]            i_req_eop,
    input  logic [NUM_IN-1:0]            i_req_val,
    output logic [NUM_IN-1:0]            o_req_rdy,
    // to multiplier
    output logic [DAT_BITS-1:0]          o_mul_dat,
    output logic [CTL_BITS-1:0]          o_mul_ctl,
    output logic                         o_mul_sop,
    output logic                         o_mul_eop,
    output logic                         o_mul_val,
    input  logic                         i_mul_rdy,
    // from multiplier
    input  logic [RES_BITS-1:0]          i_res_dat,
    input  logic [CTL_BITS-1:0]          i_res_ctl,
    input  logic                         i_res_sop,
    input  logic                         i_res_eop,
    input  logic                         i_res_val,
    output logic                         o_res_rdy,
    // results back to requesters
    output logic [NUM_IN*RES_BITS-1:0]   o_rsp_dat,
    output logic [NUM_IN*CTL_BITS-1:0]   o_rsp_ctl,
    output logic [NUM_IN-1:0]            o_rsp_sop,
    output logic [NUM_IN-1:0]            o_rsp_eop,
    output logic [NUM_IN-1:0]            o_rsp_val,
    input  logic [NUM_IN-1:0]            i_rsp_rdy,
    // debug
    output logic [INF_BITS-1:0]          o_inflight
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_BITS-1:0]  rr_ptr;
    logic [IDX_BITS-1:0]  rr_ptr_nxt;
    logic [IDX_BITS-1:0]  lock_idx;
    logic [IDX_BITS-1:0]  lock_idx_nxt;
    logic [IDX_BITS-1:0]  grant_idx;
    logic                 grant_vld;
    int                   cand;
    int                   after_grant;

    logic                 can_load;
    logic                 credit_ok;
    logic                 accept;
    logic                 req_inc;
    logic                 res_dec;

    logic [DAT_BITS-1:0]  sel_dat;
    logic [CTL_BITS-1:0]  sel_ctl;
    logic                 sel_sop;
    logic                 sel_eop;
    logic                 sel_val;
    logic [CTL_BITS-1:0]  tagged_ctl;

    logic [IDX_BITS-1:0]  dst;
    logic                 dst_ok;

    // The output register may take a new beat when empty or being drained;
    // credit stops new grants once MAX_INFLIGHT results are owed.
    assign can_load  = ~o_mul_val | i_mul_rdy;
    assign credit_ok = (o_inflight != INF_BITS'(MAX_INFLIGHT));

    // Grant selection: locked requester in LOCK, otherwise first valid from rr_ptr upward with wrap.
    always_comb begin
        grant_idx = rr_ptr;
        grant_vld = 1'b0;
        cand      = 0;
        if (state == LOCK) begin
            grant_idx = lock_idx;
            grant_vld = 1'b1;
        end else begin
            // Walk the farthest offset first so the nearest valid requester wins last.
            for (int k = NUM_IN - 1; k >= 0; k--) begin
                cand = int'(rr_ptr) + k;
                if (cand >= NUM_IN) begin
                    cand = cand - NUM_IN;
                end
                if (i_req_val[cand]) begin
                    grant_idx = IDX_BITS'(cand);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    // Mux the granted requester's beat and overwrite its tag field with the grant index.
    always_comb begin
        sel_dat    = i_req_dat[int'(grant_idx)*DAT_BITS +: DAT_BITS];
        sel_ctl    = i_req_ctl[int'(grant_idx)*CTL_BITS +: CTL_BITS];
        sel_sop    = i_req_sop[grant_idx];
        sel_eop    = i_req_eop[grant_idx];
        sel_val    = i_req_val[grant_idx];
        tagged_ctl = sel_ctl;
        tagged_ctl[OVR_WRT_BIT +: IDX_BITS] = grant_idx;
    end

    // Ready goes only to the granted requester, and never during reset.
    always_comb begin
        o_req_rdy = '0;
        if (!i_rst && grant_vld && can_load && credit_ok) begin
            o_req_rdy[grant_idx] = 1'b1;
        end
    end

    assign accept  = ~i_rst & grant_vld & sel_val & can_load & credit_ok;
    assign req_inc = accept & sel_eop;
    assign res_dec = i_res_val & o_res_rdy & i_res_eop;

    // Next-state logic: a non-eop beat locks the grant; an eop beat releases it and advances rr_ptr.
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        lock_idx_nxt = lock_idx;
        after_grant  = int'(grant_idx) + 1;
        if (after_grant >= NUM_IN) begin
            after_grant = 0;
        end
        if (accept) begin
            if (sel_eop) begin
                state_nxt  = IDLE;
                rr_ptr_nxt = IDX_BITS'(after_grant);
            end else begin
                state_nxt    = LOCK;
                lock_idx_nxt = grant_idx;
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            lock_idx <= lock_idx_nxt;
        end
    end

    // Single request register stage toward the multiplier; holds its beat while stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_mul_val <= 1'b0;
            o_mul_dat <= '0;
            o_mul_ctl <= '0;
            o_mul_sop <= 1'b0;
            o_mul_eop <= 1'b0;
        end else if (can_load) begin
            o_mul_val <= accept;
            if (accept) begin
                o_mul_dat <= sel_dat;
                o_mul_ctl <= tagged_ctl;
                o_mul_sop <= sel_sop;
                o_mul_eop <= sel_eop;
            end
        end
    end

    // Credit counter: one unit per packet (eop beat) issued, returned on each result eop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_inflight <= '0;
        end else if (req_inc && !res_dec) begin
            o_inflight <= o_inflight + 1'b1;
        end else if (res_dec && !req_inc && o_inflight != '0) begin
            o_inflight <= o_inflight - 1'b1;
        end
    end

    // Result routing: the tag selects the one lane that sees valid; payload is broadcast.
    assign dst    = i_res_ctl[OVR_WRT_BIT +: IDX_BITS];
    assign dst_ok = (int'(dst) < NUM_IN);

    // Combinational response demux; results with an out-of-range tag are swallowed.
    always_comb begin
        o_rsp_dat = {NUM_IN{i_res_dat}};
        o_rsp_ctl = {NUM_IN{i_res_ctl}};
        o_rsp_sop = {NUM_IN{i_res_sop}};
        o_rsp_eop = {NUM_IN{i_res_eop}};
        o_rsp_val = '0;
        o_res_rdy = 1'b1;
        if (dst_ok) begin
            o_res_rdy = i_rsp_rdy[dst];
            if (!i_rst) begin
                o_rsp_val[dst] = i_res_val;
            end
        end
    end

    a_bad_tag : assert property (@(posedge i_clk) disable iff (i_rst) !(i_res_val && !dst_ok));
    a_underflow : assert property (@(posedge i_clk) disable iff (i_rst)
                                   !(res_dec && !req_inc && o_inflight == '0));

endmodule

// File: tb/tb_fe_mul_arbiter.sv
// tb/tb_fe_mul_arbiter.sv - directed scoreboard bench for fe_mul_arbiter
module tb_fe_mul_arbiter;

    localparam int N   = 4;
    localparam int DB  = 16;
    localparam int RB  = 8;
    localparam int CB  = 16;
    localparam int OWB = 12;
    localparam int MAX = 4;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [N*DB-1:0]   i_req_dat;
    logic [N*CB-1:0]   i_req_ctl;
    logic [N-1:0]      i_req_sop, i_req_eop, i_req_val, o_req_rdy;
    logic [DB-1:0]     o_mul_dat;
    logic [CB-1:0]     o_mul_ctl;
    logic              o_mul_sop, o_mul_eop, o_mul_val, i_mul_rdy;
    logic [RB-1:0]     i_res_dat;
    logic [CB-1:0]     i_res_ctl;
    logic              i_res_sop, i_res_eop, i_res_val, o_res_rdy;
    logic [N*RB-1:0]   o_rsp_dat;
    logic [N*CB-1:0]   o_rsp_ctl;
    logic [N-1:0]      o_rsp_sop, o_rsp_eop, o_rsp_val, i_rsp_rdy;
    logic [2:0]        o_inflight;

    fe_mul_arbiter #(
        .NUM_IN(N), .DAT_BITS(DB), .RES_BITS(RB), .CTL_BITS(CB),
        .OVR_WRT_BIT(OWB), .MAX_INFLIGHT(MAX)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_dat(i_req_dat), .i_req_ctl(i_req_ctl), .i_req_sop(i_req_sop),
        .i_req_eop(i_req_eop), .i_req_val(i_req_val), .o_req_rdy(o_req_rdy),
        .o_mul_dat(o_mul_dat), .o_mul_ctl(o_mul_ctl), .o_mul_sop(o_mul_sop),
        .o_mul_eop(o_mul_eop), .o_mul_val(o_mul_val), .i_mul_rdy(i_mul_rdy),
        .i_res_dat(i_res_dat), .i_res_ctl(i_res_ctl), .i_res_sop(i_res_sop),
        .i_res_eop(i_res_eop), .i_res_val(i_res_val), .o_res_rdy(o_res_rdy),
        .o_rsp_dat(o_rsp_dat), .o_rsp_ctl(o_rsp_ctl), .o_rsp_sop(o_rsp_sop),
        .o_rsp_eop(o_rsp_eop), .o_rsp_val(o_rsp_val), .i_rsp_rdy(i_rsp_rdy),
        .o_inflight(o_inflight)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [DB-1:0] dat;
        logic [CB-1:0] ctl;
        logic          sop;
        logic          eop;
    } beat_t;

    beat_t lane_q[N][$];
    beat_t exp_q[$];
    beat_t mul_q[$];
    bit    auto_ret;
    int    errors = 0;
    int    checks = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue a request beat on a lane and its tagged image on the scoreboard.
    task automatic push_req(int n, logic [DB-1:0] dat, logic [CB-1:0] ctl, logic sop, logic eop);
        beat_t b;
        b.dat = dat; b.ctl = ctl; b.sop = sop; b.eop = eop;
        lane_q[n].push_back(b);
    endtask

    task automatic push_exp(int n, logic [DB-1:0] dat, logic [CB-1:0] ctl, logic sop, logic eop);
        beat_t b;
        logic [1:0] tag;
        tag = 2'(n);
        b.dat = dat; b.ctl = ctl; b.sop = sop; b.eop = eop;
        b.ctl[OWB +: 2] = tag;
        exp_q.push_back(b);
    endtask

    task automatic drive();
        for (int n = 0; n < N; n++) begin
            if (lane_q[n].size() != 0) begin
                i_req_val[n]            = 1'b1;
                i_req_dat[n*DB +: DB]   = lane_q[n][0].dat;
                i_req_ctl[n*CB +: CB]   = lane_q[n][0].ctl;
                i_req_sop[n]            = lane_q[n][0].sop;
                i_req_eop[n]            = lane_q[n][0].eop;
            end else begin
                i_req_val[n] = 1'b0;
                i_req_sop[n] = 1'b0;
                i_req_eop[n] = 1'b0;
            end
        end
        if (auto_ret) begin
            if (mul_q.size() != 0) begin
                i_res_val = 1'b1;
                i_res_ctl = mul_q[0].ctl;
                i_res_dat = mul_q[0].dat[RB-1:0];
                i_res_sop = mul_q[0].sop;
                i_res_eop = mul_q[0].eop;
            end else begin
                i_res_val = 1'b0;
            end
        end
    endtask

    // One clock: sample handshakes and score outputs at negedge, update drivers after posedge.
    task automatic tick();
        logic [N-1:0] acc;
        logic         racc;
        logic [1:0]   t;
        beat_t        e;
        @(negedge i_clk);
        acc  = i_req_val & o_req_rdy;
        racc = i_res_val & o_res_rdy;
        if (o_mul_val === 1'b1 && i_mul_rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_mul_beat", o_mul_ctl, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("mul_dat", o_mul_dat, e.dat);
                chk("mul_ctl", o_mul_ctl, e.ctl);
                chk("mul_sop_eop", {o_mul_sop, o_mul_eop}, {e.sop, e.eop});
                if (auto_ret) mul_q.push_back(e);
            end
        end
        if (auto_ret && i_res_val && mul_q.size() != 0) begin
            t = mul_q[0].ctl[OWB +: 2];
            chk("auto_rsp_val", o_rsp_val, 4'b0001 << t);
        end
        @(posedge i_clk);
        #1;
        for (int n = 0; n < N; n++) begin
            if (acc[n] === 1'b1) void'(lane_q[n].pop_front());
        end
        if (auto_ret && racc === 1'b1 && mul_q.size() != 0) void'(mul_q.pop_front());
        drive();
    endtask

    task automatic drain(string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mul_q.size() != 0 || o_inflight != 0 ||
                lane_q[0].size() + lane_q[1].size() + lane_q[2].size() + lane_q[3].size() != 0)
               && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "_drain_exp"}, exp_q.size(), 0);
        chk({tag, "_drain_inflight"}, o_inflight, 0);
        chk({tag, "_drain_budget"}, (n < 60), 1);
    endtask

    initial begin
        i_rst = 1'b1; i_mul_rdy = 1'b1; i_rsp_rdy = 4'hF;
        i_req_dat = '0; i_req_ctl = '0; i_req_sop = '0; i_req_eop = '0; i_req_val = '0;
        i_res_dat = 8'h00; i_res_ctl = 16'h1000; i_res_sop = 1'b1; i_res_eop = 1'b1; i_res_val = 1'b1;
        auto_ret = 1'b0;

        // Reset with every requester already valid and a result offered.
        push_req(0, 16'hA001, 16'hF001, 1'b1, 1'b1);
        push_req(1, 16'hA002, 16'hF002, 1'b1, 1'b1);
        push_req(2, 16'hA003, 16'hF003, 1'b1, 1'b1);
        push_req(3, 16'hA004, 16'hF004, 1'b1, 1'b1);
        push_req(0, 16'hA005, 16'hF005, 1'b1, 1'b1);
        drive();
        tick();
        tick();
        chk("rst_mul_val", o_mul_val, 0);
        chk("rst_mul_ctl", o_mul_ctl, 0);
        chk("rst_mul_dat", o_mul_dat, 0);
        chk("rst_inflight", o_inflight, 0);
        chk("rst_req_rdy", o_req_rdy, 0);
        chk("rst_rsp_val", o_rsp_val, 0);

        // Fairness: tags 0,1,2,3,0 on consecutive cycles.
        i_res_val = 1'b0; auto_ret = 1'b1; i_rst = 1'b0;
        push_exp(0, 16'hA001, 16'hF001, 1'b1, 1'b1);
        push_exp(1, 16'hA002, 16'hF002, 1'b1, 1'b1);
        push_exp(2, 16'hA003, 16'hF003, 1'b1, 1'b1);
        push_exp(3, 16'hA004, 16'hF004, 1'b1, 1'b1);
        push_exp(0, 16'hA005, 16'hF005, 1'b1, 1'b1);
        #1;
        chk("rr_first_rdy", o_req_rdy, 4'b0001);
        chk("rr_no_val_yet", o_mul_val, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_consecutive_val", o_mul_val, 1);
        end
        drain("rr");

        // Locked 3-beat packet on lane 2 amid lanes 1 and 3.
        push_req(1, 16'hB001, 16'h0101, 1'b1, 1'b1);
        push_req(2, 16'hB002, 16'h0202, 1'b1, 1'b0);
        push_req(2, 16'hB003, 16'h0203, 1'b0, 1'b0);
        push_req(2, 16'hB004, 16'h0204, 1'b0, 1'b1);
        push_req(3, 16'hB005, 16'h0305, 1'b1, 1'b1);
        push_req(1, 16'hB006, 16'h0106, 1'b1, 1'b1);
        push_exp(1, 16'hB001, 16'h0101, 1'b1, 1'b1);
        push_exp(2, 16'hB002, 16'h0202, 1'b1, 1'b0);
        push_exp(2, 16'hB003, 16'h0203, 1'b0, 1'b0);
        push_exp(2, 16'hB004, 16'h0204, 1'b0, 1'b1);
        push_exp(3, 16'hB005, 16'h0305, 1'b1, 1'b1);
        push_exp(1, 16'hB006, 16'h0106, 1'b1, 1'b1);
        drive();
        tick();
        tick();
        chk("lock_rdy_beat2", o_req_rdy, 4'b0100);
        tick();
        chk("lock_rdy_beat3", o_req_rdy, 4'b0100);
        drain("lock");

        // Result routing to lane 1 with 5 cycles of requester backpressure.
        auto_ret = 1'b0;
        push_req(1, 16'hC055, 16'h00AB, 1'b1, 1'b1);
        push_exp(1, 16'hC055, 16'h00AB, 1'b1, 1'b1);
        drive();
        tick();
        tick();
        chk("route_inflight", o_inflight, 1);
        i_res_val = 1'b1; i_res_ctl = 16'h10AB; i_res_dat = 8'h55; i_res_sop = 1'b1; i_res_eop = 1'b1;
        i_rsp_rdy = 4'b1101;
        #1;
        chk("route_rsp_val", o_rsp_val, 4'b0010);
        chk("route_rsp_dat1", o_rsp_dat[RB +: RB], 8'h55);
        chk("route_rsp_ctl1", o_rsp_ctl[CB +: CB], 16'h10AB);
        for (int i = 0; i < 5; i++) begin
            chk("route_stall_res_rdy", o_res_rdy, 0);
            chk("route_stall_inflight", o_inflight, 1);
            tick();
        end
        i_rsp_rdy = 4'hF;
        #1;
        chk("route_res_rdy", o_res_rdy, 1);
        tick();
        i_res_val = 1'b0;
        #1;
        chk("route_inflight_ret", o_inflight, 0);

        // Credit limit: six requests on lane 0, no results returned.
        for (int i = 0; i < 6; i++) begin
            push_req(0, 16'hD000 + 16'(i), 16'h0040 + 16'(i), 1'b1, 1'b1);
            push_exp(0, 16'hD000 + 16'(i), 16'h0040 + 16'(i), 1'b1, 1'b1);
        end
        drive();
        repeat (6) tick();
        chk("credit_full", o_inflight, 4);
        chk("credit_blocked_rdy", o_req_rdy, 0);
        chk("credit_pending", lane_q[0].size(), 2);
        i_res_val = 1'b1; i_res_ctl = 16'h0040; i_res_dat = 8'h00; i_res_sop = 1'b1; i_res_eop = 1'b1;
        #1;
        chk("credit_ret_rdy", o_res_rdy, 1);
        chk("credit_ret_req_rdy", o_req_rdy, 0);
        tick();
        i_res_val = 1'b0;
        #1;
        chk("credit_after_ret", o_inflight, 3);
        chk("credit_fifth_rdy", o_req_rdy, 4'b0001);
        tick();
        chk("credit_fifth_acc", o_inflight, 4);
        chk("credit_reblocked", o_req_rdy, 0);
        i_res_val = 1'b1;
        tick();
        #1;
        chk("credit_sixth_rdy", o_req_rdy, 4'b0001);
        tick();
        chk("credit_simul_inc_dec", o_inflight, 3);
        repeat (3) tick();
        i_res_val = 1'b0;
        #1;
        chk("credit_empty", o_inflight, 0);
        chk("credit_exp_empty", exp_q.size(), 0);

        // Multiplier stall: beat held stable for 10 cycles.
        auto_ret = 1'b1;
        i_mul_rdy = 1'b0;
        push_req(3, 16'hE003, 16'h0E03, 1'b1, 1'b1);
        push_req(0, 16'hE000, 16'h0E00, 1'b1, 1'b1);
        push_exp(3, 16'hE003, 16'h0E03, 1'b1, 1'b1);
        push_exp(0, 16'hE000, 16'h0E00, 1'b1, 1'b1);
        drive();
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("stall_val", o_mul_val, 1);
            chk("stall_dat", o_mul_dat, 16'hE003);
            chk("stall_ctl", o_mul_ctl, 16'h3E03);
            chk("stall_req_rdy", o_req_rdy, 0);
            tick();
        end
        i_mul_rdy = 1'b1;
        #1;
        chk("stall_release_rdy", o_req_rdy, 4'b0001);
        drain("stall");

        // Reset in the middle of a locked packet.
        push_req(2, 16'hF002, 16'h0F02, 1'b1, 1'b0);
        push_req(2, 16'hF003, 16'h0F03, 1'b0, 1'b0);
        push_req(2, 16'hF004, 16'h0F04, 1'b0, 1'b1);
        push_exp(2, 16'hF002, 16'h0F02, 1'b1, 1'b0);
        drive();
        tick();
        chk("midrst_locked", o_req_rdy, 4'b0100);
        i_rst = 1'b1;
        #1;
        chk("midrst_rdy_in_rst", o_req_rdy, 0);
        tick();
        i_rst = 1'b0;
        lane_q[2].delete();
        mul_q.delete();
        push_req(1, 16'hF101, 16'h0F11, 1'b1, 1'b1);
        push_req(3, 16'hF303, 16'h0F33, 1'b1, 1'b1);
        push_exp(1, 16'hF101, 16'h0F11, 1'b1, 1'b1);
        push_exp(3, 16'hF303, 16'h0F33, 1'b1, 1'b1);
        drive();
        #1;
        chk("midrst_mul_val", o_mul_val, 0);
        chk("midrst_inflight", o_inflight, 0);
        chk("midrst_idle_rr0", o_req_rdy, 4'b0010);
        drain("midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
